// File: rtl/modem_symbol_scheduler_pkg.sv
// rtl/modem_symbol_scheduler_pkg.sv - modulation codes, per-modulation settings and scheduler states
package modem_symbol_scheduler_pkg;

  localparam int MAX_SYMBOL_SIZE = 3;

  typedef enum logic [1:0] {
    MOD_BPSK = 2'd0,
    MOD_QPSK = 2'd1,
    MOD_PSK8 = 2'd2
  } t_modulation;

  typedef struct packed {
    logic [1:0] symbol_size;
  } t_mod_settings;

  typedef enum logic [1:0] {
    SCH_IDLE,
    SCH_RUN,
    SCH_DRAIN
  } t_sched_state;

  // Unassigned code 3 falls back to BPSK so a bad config still yields a valid stream.
  function automatic t_mod_settings get_modulation_settings(input logic [1:0] code);
    t_mod_settings s;
    s.symbol_size = 2'd1;
    case (code)
      2'd1:    s.symbol_size = 2'd2;
      2'd2:    s.symbol_size = 2'd3;
      default: s.symbol_size = 2'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/modem_symbol_scheduler_if.sv
// rtl/modem_symbol_scheduler_if.sv - byte-in / symbol-out handshake bundle of the symbol scheduler
interface modem_symbol_scheduler_if
  import modem_symbol_scheduler_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [1:0]                 cfg_mod;
  logic [DATA_W-1:0]          s_data;
  logic                       s_valid;
  logic                       s_last;
  logic                       s_ready;
  logic [MAX_SYMBOL_SIZE-1:0] m_sym;
  logic [1:0]                 m_sym_size;
  logic                       m_valid;
  logic                       m_last;
  logic                       m_ready;

  modport slave (
    input  cfg_mod, s_data, s_valid, s_last, m_ready,
    output s_ready, m_sym, m_sym_size, m_valid, m_last
  );

  modport master (
    output cfg_mod, s_data, s_valid, s_last, m_ready,
    input  s_ready, m_sym, m_sym_size, m_valid, m_last
  );

endinterface

// File: rtl/modem_symbol_scheduler.sv
// rtl/modem_symbol_scheduler.sv - splits framed bytes into MSB-first BPSK/QPSK/PSK8 mapper symbols
module modem_symbol_scheduler
  import modem_symbol_scheduler_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BUF_W  = DATA_W + 8
) (
  input logic                    clk,
  input logic                    rst_n,
  modem_symbol_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] HEAD_CNT = CNT_W'(BUF_W - DATA_W);

  t_sched_state               state, state_nxt;
  logic [CNT_W-1:0]           count, count_nxt;
  logic [BUF_W-1:0]           buffer, buffer_nxt;
  logic [1:0]                 size, size_nxt;

  logic [CNT_W-1:0]           size_cnt;
  logic [CNT_W-1:0]           cnt_emit;
  logic [BUF_W-1:0]           buf_emit;
  logic [BUF_W-1:0]           word_ext;
  logic [MAX_SYMBOL_SIZE-1:0] head;
  t_mod_settings              mod_set;
  logic                       s_ready;
  logic                       m_valid;
  logic                       m_last;
  logic                       in_fire;
  logic                       out_fire;

  assign size_cnt = CNT_W'(size);
  assign word_ext = BUF_W'(bus.s_data);
  assign head     = buffer[BUF_W-1 -: MAX_SYMBOL_SIZE];
  assign mod_set  = get_modulation_settings(bus.cfg_mod);

  // Handshake decode uses registered state only, so s_ready never depends on m_ready.
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    case (state)
      SCH_IDLE: s_ready = 1'b1;
      SCH_RUN: begin
        s_ready = (count < (size_cnt << 1));
        m_valid = (count >= size_cnt);
      end
      SCH_DRAIN: begin
        m_valid = (count != '0);
        m_last  = (count <= size_cnt);
      end
      default: ;
    endcase
  end

  assign in_fire  = bus.s_valid && s_ready;
  assign out_fire = m_valid && bus.m_ready;

  assign bus.s_ready    = s_ready;
  assign bus.m_valid    = m_valid;
  assign bus.m_last     = m_last;
  assign bus.m_sym_size = size;
  // Bits below count are always zero, so a short final symbol comes out zero-padded.
  assign bus.m_sym      = head >> (2'(MAX_SYMBOL_SIZE) - size);

  always_comb begin
    buf_emit   = out_fire ? (buffer << size) : buffer;
    cnt_emit   = out_fire ? (count - size_cnt) : count;
    state_nxt  = state;
    count_nxt  = cnt_emit;
    buffer_nxt = buf_emit;
    size_nxt   = size;
    case (state)
      SCH_IDLE: begin
        if (in_fire) begin
          size_nxt   = mod_set.symbol_size;
          buffer_nxt = word_ext << HEAD_CNT;
          count_nxt  = WORD_CNT;
          state_nxt  = bus.s_last ? SCH_DRAIN : SCH_RUN;
        end
      end
      SCH_RUN: begin
        if (in_fire) begin
          buffer_nxt = buf_emit | (word_ext << (HEAD_CNT - cnt_emit));
          count_nxt  = cnt_emit + WORD_CNT;
          if (bus.s_last) state_nxt = SCH_DRAIN;
        end
      end
      SCH_DRAIN: begin
        if (out_fire && m_last) begin
          state_nxt  = SCH_IDLE;
          count_nxt  = '0;
          buffer_nxt = '0;
        end
      end
      default: state_nxt = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SCH_IDLE;
      count  <= '0;
      buffer <= '0;
      size   <= 2'd1;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      buffer <= buffer_nxt;
      size   <= size_nxt;
    end
  end

endmodule

// File: tb/tb_modem_symbol_scheduler.sv
// tb/tb_modem_symbol_scheduler.sv - directed vector bench for modem_symbol_scheduler
module tb_modem_symbol_scheduler;
  import modem_symbol_scheduler_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  modem_symbol_scheduler_if #(.DATA_W(8)) bus();

  modem_symbol_scheduler #(.DATA_W(8), .BUF_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [1:0]  mod;
    logic [1:0]  cfg_after;
    logic [3:0]  nw;
    logic [31:0] words;
    logic [4:0]  nsym;
    logic [1:0]  size;
    logic [63:0] syms;
  } vec_t;

  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0] got_sym[64];
  bit         got_last[64];
  int         got_sz[64];
  int         got_n;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_syms(input logic [31:0] w, input int nw, input int sz,
                                             output int ns);
    logic [63:0] r;
    logic [3:0]  s;
    int          nb;
    int          p;
    r  = '0;
    nb = 8 * nw;
    ns = (nb + sz - 1) / sz;
    for (int k = 0; k < ns; k++) begin
      s = '0;
      for (int j = 0; j < sz; j++) begin
        p = k * sz + j;
        s = {s[2:0], (p < nb) ? w[nb-1-p] : 1'b0};
      end
      r[4*(ns-1-k) +: 4] = s;
    end
    return r;
  endfunction

  task automatic run_frame(input vec_t v, input bit rnd, input string tag);
    int         wi     = 0;
    int         cyc    = 0;
    int         bits   = 0;
    int         acc_c  = -1;
    int         val_c  = -1;
    int         nw     = int'(v.nw);
    int         ns     = int'(v.nsym);
    int         sz     = int'(v.size);
    bit         done   = 1'b0;
    bit         held_v = 1'b0;
    logic [2:0] held_sym = '0;
    bit         held_last = 1'b0;
    got_n = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      bus.cfg_mod = (wi == 0) ? v.mod : v.cfg_after;
      bus.s_valid = (wi < nw);
      if (wi < nw) bus.s_data = v.words[8*(nw-1-wi) +: 8];
      else         bus.s_data = 8'h00;
      bus.s_last  = (wi == nw - 1);
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (held_v) begin
        chk({tag, "_stall_valid"}, int'(bus.m_valid), 1);
        chk({tag, "_stall_sym"},   int'(bus.m_sym), int'(held_sym));
        chk({tag, "_stall_last"},  int'(bus.m_last), int'(held_last));
      end
      if (bits >= 2 * sz) chk({tag, "_s_ready_full"}, int'(bus.s_ready), 0);
      if (bus.m_valid && val_c < 0) val_c = cyc;
      if (bus.s_valid && bus.s_ready) begin
        if (acc_c < 0) acc_c = cyc;
        wi++;
        bits += 8;
      end
      held_v    = bus.m_valid && !bus.m_ready;
      held_sym  = bus.m_sym;
      held_last = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        if (got_n < 64) begin
          got_sym[got_n]  = bus.m_sym;
          got_last[got_n] = bus.m_last;
          got_sz[got_n]   = int'(bus.m_sym_size);
        end
        got_n++;
        bits -= sz;
        if (bus.m_last) done = 1'b1;
      end
      cyc++;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_nsym"}, got_n, ns);
    for (int k = 0; k < ns && k < got_n && k < 64; k++) begin
      chk($sformatf("%s_sym%0d", tag, k),  int'(got_sym[k]), int'(v.syms[4*(ns-1-k) +: 4]));
      chk($sformatf("%s_last%0d", tag, k), int'(got_last[k]), (k == ns - 1) ? 1 : 0);
      chk($sformatf("%s_size%0d", tag, k), got_sz[k], sz);
    end
    if (!rnd) chk({tag, "_latency"}, val_c - acc_c, 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    #1;
    chk({tag, "_idle_s_ready"}, int'(bus.s_ready), 1);
    chk({tag, "_idle_m_valid"}, int'(bus.m_valid), 0);
  endtask

  initial begin
    vec_t v;
    int   ns;

    //            mod    after  nw    words          nsym   size   symbols (first digit first)
    vecs[0] = '{2'd1, 2'd1, 4'd1, 32'h000000B4, 5'd4,  2'd2, 64'h2310};
    vecs[1] = '{2'd2, 2'd2, 4'd1, 32'h000000FF, 5'd3,  2'd3, 64'h776};
    vecs[2] = '{2'd2, 2'd2, 4'd1, 32'h000000B4, 5'd3,  2'd3, 64'h550};
    vecs[3] = '{2'd0, 2'd0, 4'd2, 32'h0000A50F, 5'd16, 2'd1, 64'h1010010100001111};
    vecs[4] = '{2'd1, 2'd2, 4'd2, 32'h00001EC3, 5'd8,  2'd2, 64'h01323003};
    vecs[5] = '{2'd2, 2'd2, 4'd2, 32'h00001234, 5'd6,  2'd3, 64'h044320};
    vecs[6] = '{2'd2, 2'd0, 4'd3, 32'h00ABCDEF, 5'd8,  2'd3, 64'h52746757};
    vecs[7] = '{2'd3, 2'd1, 4'd1, 32'h00000080, 5'd8,  2'd1, 64'h10000000};

    bus.cfg_mod = 2'd0;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;

    #12;
    chk("rst_s_ready", int'(bus.s_ready), 1);
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_last",  int'(bus.m_last), 0);
    chk("rst_m_sym",   int'(bus.m_sym), 0);
    chk("rst_m_size",  int'(bus.m_sym_size), 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));

    v = '{2'd1, 2'd1, 4'd4, 32'h3C965AE1, 5'd0, 2'd2, 64'h0};
    v.syms = model_syms(v.words, 4, 2, ns);
    v.nsym = 5'(ns);
    run_frame(v, 1'b1, "rnd_qpsk");

    v = '{2'd2, 2'd2, 4'd4, 32'h3C965AE1, 5'd0, 2'd3, 64'h0};
    v.syms = model_syms(v.words, 4, 3, ns);
    v.nsym = 5'(ns);
    run_frame(v, 1'b1, "rnd_psk8");

    // Asynchronous reset in the middle of a PSK8 frame.
    @(negedge clk);
    bus.cfg_mod = 2'd2;
    bus.s_data  = 8'hAB;
    bus.s_valid = 1'b1;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1;
    chk("pre_rst_m_valid", int'(bus.m_valid), 1);
    chk("pre_rst_size",    int'(bus.m_sym_size), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", int'(bus.m_valid), 0);
    chk("mid_rst_s_ready", int'(bus.s_ready), 1);
    chk("mid_rst_size",    int'(bus.m_sym_size), 1);
    chk("mid_rst_m_sym",   int'(bus.m_sym), 0);
    chk("mid_rst_m_last",  int'(bus.m_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(vecs[2], 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
